bcd_seq: RTL and testbench



---
 rtl/bcd_seq.sv | 136 +++++++++++++
 tb/tb_bcd_seq.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_seq.sv
// rtl/bcd_seq.sv - iterative double-dabble binary-to-BCD converter, one bit per clock
// Optional leading-zero mask port "blank" when BCD_SEQ_BLANK_EN is defined.
module bcd_seq #(
    parameter int WIDTH  = 16,
    parameter int DIGITS = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
`ifdef BCD_SEQ_BLANK_EN
    ,
    output logic [DIGITS-1:0]     blank
`endif
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WIDTH-1:0]      sr_q, sr_d;
    logic [4*DIGITS-1:0]   scr_q, scr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [4*DIGITS-1:0]   bcd_q, bcd_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic [4*DIGITS-1:0]   scr_adj;
    logic [4*DIGITS-1:0]   scr_shift;

`ifdef BCD_SEQ_BLANK_EN
    logic [DIGITS-1:0]     blank_q, blank_d;
    logic                  zero_above;
`endif

    // One double-dabble step: add-3 correction, then shift sr's MSB into digit 0.
    always_comb begin
        scr_adj = scr_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scr_q[4*i +: 4] >= 4'd5) begin
                scr_adj[4*i +: 4] = scr_q[4*i +: 4] + 4'd3;
            end
        end
        scr_shift = {scr_adj[4*DIGITS-2:0], sr_q[WIDTH-1]};
    end

    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        scr_d   = scr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    sr_d    = binary;
                    scr_d   = '0;
                    cnt_d   = CW'(WIDTH - 1);
                    busy_d  = 1'b1;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                sr_d  = {sr_q[WIDTH-2:0], 1'b0};
                scr_d = scr_shift;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    bcd_d   = scr_shift;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef BCD_SEQ_BLANK_EN
    // Digit i is blanked only if it and every higher digit are zero; digit 0 always shows.
    always_comb begin
        blank_d    = blank_q;
        zero_above = 1'b1;
        if (done_d) begin
            for (int i = DIGITS - 1; i >= 1; i--) begin
                zero_above = zero_above & (bcd_d[4*i +: 4] == 4'd0);
                blank_d[i] = zero_above;
            end
            blank_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blank_q <= {{(DIGITS-1){1'b1}}, 1'b0};
        end else begin
            blank_q <= blank_d;
        end
    end

    assign blank = blank_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            scr_q   <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            scr_q   <= scr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;

endmodule

// File: tb/tb_bcd_seq.sv
// tb/tb_bcd_seq.sv - directed self-checking bench for bcd_seq
// Blank-mask checks are active when BCD_SEQ_BLANK_EN is defined.
module tb_bcd_seq;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] binary;
    logic        busy;
    logic        done;
    logic [19:0] bcd;
`ifdef BCD_SEQ_BLANK_EN
    logic [4:0]  blank;
`endif

    int passed = 0;
    int total  = 0;

    bcd_seq #(.WIDTH(16), .DIGITS(5)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .binary (binary),
        .busy   (busy),
        .done   (done),
        .bcd    (bcd)
`ifdef BCD_SEQ_BLANK_EN
        ,
        .blank  (blank)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accept a start at the next rising edge (E0); returns at the falling edge after E0.
    task automatic launch(input logic [15:0] v);
        start  = 1'b1;
        binary = v;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Counts rising edges after E0 until done is seen at a falling edge; bounded.
    task automatic wait_done(output int cyc, output logic ok);
        cyc = 0;
        ok  = 1'b0;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (done) ok = 1'b1;
        end
    endtask

    task automatic convert(input string name, input logic [15:0] v,
                           input logic [19:0] exp_bcd, input logic [4:0] exp_blank);
        int   cyc;
        logic ok;
        launch(v);
        total++;
        if (busy !== 1'b1) $display("FAIL %s busy_after_start: got %b want 1", name, busy);
        else passed++;
        wait_done(cyc, ok);
        total++;
        if (!ok || cyc != 16) $display("FAIL %s latency: got %0d (seen=%b) want 16", name, cyc, ok);
        else passed++;
        total++;
        if (bcd !== exp_bcd) $display("FAIL %s bcd: got %h want %h", name, bcd, exp_bcd);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL %s busy_in_done: got %b want 0", name, busy);
        else passed++;
`ifdef BCD_SEQ_BLANK_EN
        total++;
        if (blank !== exp_blank) $display("FAIL %s blank: got %b want %b", name, blank, exp_blank);
        else passed++;
`endif
        @(negedge clk);
        total++;
        if (done !== 1'b0 || bcd !== exp_bcd)
            $display("FAIL %s done_one_cycle: done=%b bcd=%h want 0/%h", name, done, bcd, exp_bcd);
        else passed++;
    endtask

    task automatic test_reset;
        rst_n  = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0)
            $display("FAIL reset_outputs: busy=%b done=%b bcd=%h want 0/0/00000", busy, done, bcd);
        else passed++;
`ifdef BCD_SEQ_BLANK_EN
        total++;
        if (blank !== 5'b11110) $display("FAIL reset_blank: got %b want 11110", blank);
        else passed++;
`endif
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_max;
        convert("max", 16'hFFFF, 20'h65535, 5'b00000);
    endtask

    task automatic test_zero;
        convert("zero", 16'd0, 20'h00000, 5'b11110);
    endtask

    task automatic test_divider;
        convert("div15", 16'd15, 20'h00015, 5'b11100);
        convert("div1234", 16'd1234, 20'h01234, 5'b10000);
    endtask

    task automatic test_ignored_start;
        int ndone = 0;
        int dcyc  = -1;
        launch(16'd4321);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (done) begin
                ndone++;
                dcyc = c;
            end
            start  = (c == 3 || c == 10);
            binary = 16'd7777;
        end
        start = 1'b0;
        total++;
        if (ndone != 1 || dcyc != 16)
            $display("FAIL ignored_start_done: count=%0d at=%0d want 1 at 16", ndone, dcyc);
        else passed++;
        total++;
        if (bcd !== 20'h04321) $display("FAIL ignored_start_bcd: got %h want 04321", bcd);
        else passed++;
        total++;
        if (busy !== 1'b0) $display("FAIL ignored_start_not_queued: busy=%b want 0", busy);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int   d1 = -1;
        int   d2 = -1;
        int   bad_busy = 0;
        logic [19:0] b1 = 'x;
        logic [19:0] b2 = 'x;
        start  = 1'b1;
        binary = 16'd100;
        for (int c = 0; c <= 34; c++) begin
            @(posedge clk);
            @(negedge clk);
            if (c >= 1 && c <= 33 && busy !== !done) bad_busy++;
            if (done && d1 < 0) begin
                d1 = c;
                b1 = bcd;
                binary = 16'd9999;
            end else if (done && d2 < 0) begin
                d2 = c;
                b2 = bcd;
                start = 1'b0;
            end
        end
        start = 1'b0;
        total++;
        if (d1 != 16 || b1 !== 20'h00100)
            $display("FAIL b2b_first: at=%0d bcd=%h want 16/00100", d1, b1);
        else passed++;
        total++;
        if (d2 != 33 || b2 !== 20'h09999)
            $display("FAIL b2b_second: at=%0d bcd=%h want 33/09999", d2, b2);
        else passed++;
        total++;
        if (bad_busy != 0) $display("FAIL b2b_busy_vs_done: %0d bad cycles want 0", bad_busy);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int ndone = 0;
        launch(16'd500);
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 20'h0)
            $display("FAIL reset_mid_clear: busy=%b done=%b bcd=%h want 0/0/00000", busy, done, bcd);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        total++;
        if (ndone != 0) $display("FAIL reset_mid_no_done: got %0d pulses want 0", ndone);
        else passed++;
        convert("after_reset", 16'd500, 20'h00500, 5'b11000);
    endtask

    initial begin
        test_reset();
        test_max();
        test_zero();
        test_divider();
        test_ignored_start();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
